ps2_key_rx: RTL and testbench

- Receives PS/2 keyboard frames on ps2_clk/ps2_data, which are the commented-out inputs of the game top.
- Validates each 11-bit frame and emits one-cycle scan-code strobes.
- Decodes make/break sequences, including E0 and F0 prefixes, into held key levels that drive Jack's movement state (stand/run/jump).
- Sits between the board PS/2 pins and the player-control logic, on the 100 MHz clk domain.

---
 rtl/ps2_key_rx.sv | 163 ++++++++++++++++
 tb/tb_ps2_key_rx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_rx.sv
// rtl/ps2_key_rx.sv - PS/2 keyboard frame receiver with make/break key-level decoder.
// Optional: define PS2_ERR_COUNT_EN to build the saturating frame-error counter.
module ps2_key_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err,
    output logic       key_left,
    output logic       key_right,
    output logic       key_jump,
    output logic [7:0] err_count
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1, clk_s2, data_s1, data_s2;
    logic          clk_f;
    logic [FW-1:0] fcnt;
    logic          flip, fall;
    logic          fall_r, bit_r;
    state_t        state;
    logic [2:0]    bidx;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] tcnt;
    logic          ext, brk;
    logic          k_left, k_right, k_space, k_up;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    assign flip = (clk_s2 != clk_f) && (fcnt == FW'(FILTER_LEN - 1));
    assign fall = flip && clk_f;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_f  <= 1'b1;
            fcnt   <= '0;
            fall_r <= 1'b0;
            bit_r  <= 1'b0;
        end else begin
            if (clk_s2 == clk_f) begin
                fcnt <= '0;
            end else if (flip) begin
                fcnt  <= '0;
                clk_f <= clk_s2;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
            fall_r <= fall;
            bit_r  <= data_s2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bidx       <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            tcnt       <= '0;
            scan_code  <= '0;
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
            ext        <= 1'b0;
            brk        <= 1'b0;
            k_left     <= 1'b0;
            k_right    <= 1'b0;
            k_space    <= 1'b0;
            k_up       <= 1'b0;
        end else begin
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;

            if (state == IDLE || fall) tcnt <= '0;
            else                       tcnt <= tcnt + 1'b1;

            if (scan_valid) begin
                if (scan_code == 8'hE0) begin
                    ext <= 1'b1;
                end else if (scan_code == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    if (!ext && scan_code == 8'h29) k_space <= !brk;
                    if (ext  && scan_code == 8'h6B) k_left  <= !brk;
                    if (ext  && scan_code == 8'h74) k_right <= !brk;
                    if (ext  && scan_code == 8'h75) k_up    <= !brk;
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            end

            if (fall_r) begin
                case (state)
                    IDLE: begin
                        if (!bit_r) begin
                            state <= DATA;
                            bidx  <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg <= {bit_r, shreg[7:1]};
                        bidx  <= bidx + 1'b1;
                        if (bidx == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par   <= bit_r;
                        state <= STOP;
                    end
                    default: begin
                        if (bit_r && (^shreg ^ par)) begin
                            scan_code  <= shreg;
                            scan_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                endcase
            // frame_err lands one cycle after the match, i.e. TIMEOUT_CYC cycles after the last accepted edge
            end else if (state != IDLE && tcnt == TW'(TIMEOUT_CYC - 2)) begin
                frame_err <= 1'b1;
                state     <= IDLE;
                ext       <= 1'b0;
                brk       <= 1'b0;
            end
        end
    end

    assign key_left  = k_left;
    assign key_right = k_right;
    assign key_jump  = k_space | k_up;

`ifdef PS2_ERR_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             err_count <= '0;
        else if (frame_err && err_count != 8'hFF) err_count <= err_count + 1'b1;
    end
`else
    assign err_count = '0;
`endif
endmodule

// File: tb/tb_ps2_key_rx.sv
// tb/tb_ps2_key_rx.sv - directed self-checking bench for ps2_key_rx (honours PS2_ERR_COUNT_EN).
module tb_ps2_key_rx;
    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 400;
    localparam int H           = 40;
    localparam int LAT         = FILTER_LEN + 3;
    localparam int TO_DLY      = TIMEOUT_CYC + FILTER_LEN + 1;
`ifdef PS2_ERR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scan_code;
    logic       scan_valid, frame_err, key_left, key_right, key_jump;
    logic [7:0] err_count;

    int vectors = 0;
    int miscompares = 0;
    int sv_cnt = 0, fe_cnt = 0, both_cnt = 0;
    int sv0, fe0, lat, dly;

    ps2_key_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .scan_code(scan_code), .scan_valid(scan_valid), .frame_err(frame_err),
        .key_left(key_left), .key_right(key_right), .key_jump(key_jump),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (scan_valid) sv_cnt++;
        if (frame_err) fe_cnt++;
        if (scan_valid && frame_err) both_cnt++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int keys();
        return int'({key_left, key_right, key_jump});
    endfunction

    function automatic int errs(input int n);
        return CNT_EN ? n : 0;
    endfunction

    task automatic send_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (H / 2) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (H / 2) @(negedge clk);
    endtask

    // lat: clk edges from the stop-bit fall until scan_valid or frame_err is first seen (0 = never)
    task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic bad_stop,
                              output int l);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(code[i]);
        send_bit(~^code ^ bad_par);
        @(negedge clk) ps2_data = ~bad_stop;
        repeat (H / 2) @(negedge clk);
        ps2_clk = 1'b0;
        l = 0;
        for (int i = 1; i <= H; i++) begin
            @(negedge clk);
            if ((scan_valid || frame_err) && l == 0) l = i;
        end
        ps2_clk = 1'b1;
        repeat (H / 2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] code);
        int l;
        send_frame(code, 1'b0, 1'b0, l);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check("rst_scan_code", int'(scan_code), 0);
        check("rst_pulses", int'({scan_valid, frame_err}), 0);
        check("rst_keys", keys(), 0);
        check("rst_err_count", int'(err_count), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        sv0 = sv_cnt; fe0 = fe_cnt;
        send_frame(8'h1C, 1'b0, 1'b0, lat);
        check("1c_latency", lat, LAT);
        check("1c_code", int'(scan_code), 'h1C);
        check("1c_valid_cnt", sv_cnt - sv0, 1);
        check("1c_err_cnt", fe_cnt - fe0, 0);

        send_byte(8'hE0);
        check("e0_keys", keys(), 0);
        send_byte(8'h6B);
        check("left_make", keys(), 'b100);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
        check("left_break", keys(), 0);

        send_byte(8'h29);
        check("space_make", keys(), 'b001);
        send_byte(8'hE0); send_byte(8'h75);
        check("up_make", keys(), 'b001);
        send_byte(8'hF0); send_byte(8'h29);
        check("space_break_up_held", keys(), 'b001);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        check("up_break", keys(), 0);

        send_byte(8'hE0); send_byte(8'h74);
        check("right_make", keys(), 'b010);
        sv0 = sv_cnt; fe0 = fe_cnt;
        send_frame(8'h29, 1'b1, 1'b0, lat);
        check("par_err_latency", lat, LAT);
        check("par_err_cnt", fe_cnt - fe0, 1);
        check("par_err_no_valid", sv_cnt - sv0, 0);
        check("par_err_keys", keys(), 'b010);
        check("par_err_code_kept", int'(scan_code), 'h74);
        check("par_err_count", int'(err_count), errs(1));
        send_frame(8'h29, 1'b0, 1'b1, lat);
        check("stop_err_cnt", fe_cnt - fe0, 2);
        send_bit(1'b1);
        check("start_err_cnt", fe_cnt - fe0, 3);
        check("start_err_no_valid", sv_cnt - sv0, 0);
        check("err_keys", keys(), 'b010);
        check("err_count_3", int'(err_count), errs(3));
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
        check("right_break", keys(), 0);

        // E0 prefix pending when the frame times out must be dropped
        send_byte(8'hE0);
        sv0 = sv_cnt; fe0 = fe_cnt;
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        @(negedge clk) ps2_data = 1'b1;
        repeat (H / 2) @(negedge clk);
        ps2_clk = 1'b0;
        dly = 0;
        for (int i = 1; i <= TO_DLY + 100; i++) begin
            @(negedge clk);
            if (i == H) ps2_clk = 1'b1;
            if (frame_err && dly == 0) dly = i;
        end
        check("timeout_delay", dly, TO_DLY);
        check("timeout_err_cnt", fe_cnt - fe0, 1);
        check("timeout_no_valid", sv_cnt - sv0, 0);
        check("timeout_err_count", int'(err_count), errs(4));
        send_byte(8'h29);
        check("post_to_code", int'(scan_code), 'h29);
        check("post_to_space", keys(), 'b001);

        sv0 = sv_cnt; fe0 = fe_cnt;
        for (int g = 1; g <= 3; g++) begin
            @(negedge clk) ps2_clk = 1'b0;
            repeat (g) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (20) @(negedge clk);
        end
        check("glitch_no_err", fe_cnt - fe0, 0);
        check("glitch_no_valid", sv_cnt - sv0, 0);
        check("glitch_keys", keys(), 'b001);

        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_outputs", int'({scan_code, scan_valid, frame_err, key_left, key_right, key_jump}), 0);
        check("midrst_err_count", int'(err_count), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        send_frame(8'h1C, 1'b0, 1'b0, lat);
        check("post_rst_latency", lat, LAT);
        check("post_rst_code", int'(scan_code), 'h1C);
        check("post_rst_valid_cnt", sv_cnt - sv0, 1);
        check("post_rst_err_cnt", fe_cnt - fe0, 0);
        check("post_rst_keys", keys(), 0);
        check("never_both", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
